fp_regfile_mp: RTL and testbench
================================

FP_REGFILE_MP -- requirements
Module: fp_regfile_mp

Interface
REQ-001 Parameter DEPTH, default 32: number of FP registers; power of two, at least 2.
REQ-002 Parameter DATA_WIDTH, default riscv_pkg::FpWidth: register width; 32 or 64.
REQ-003 Parameter NUM_RD, default 3: read port count, 1..4 (fs1/fs2/fs3 minimum for FMA).
REQ-004 Parameter NUM_WR, default 2: write port count, 1..2 (port 0 FPU completion, port 1 FP load).
REQ-005 Port i_clk  in  1  sole clock; all state rises on posedge.
REQ-006 Port i_rst_n  in  1  asynchronous active-low reset.
REQ-007 Port i_stall  in  1  pipeline stall; freezes read registers, writes, issue.
REQ-008 Port i_rd_addr  in  NUM_RD x AW  read addresses (PD-stage early regs); AW = clog2(DEPTH).
REQ-009 Port o_rd_data  out  NUM_RD x DATA_WIDTH  registered read data.
REQ-010 Port o_rd_busy  out  NUM_RD  registered scoreboard busy bit of each addressed register.
REQ-011 Port i_wr_en  in  NUM_WR  write enable per port.
REQ-012 Port i_wr_addr  in  NUM_WR x AW  write address (tracked fp_dest_reg).
REQ-013 Port i_wr_data  in  NUM_WR x DATA_WIDTH  write data.
REQ-014 Port i_wr_single  in  NUM_WR  write carries a single-precision result.
REQ-015 Port i_iss_en  in  1  long-latency FP op issued; marks its destination busy.
REQ-016 Port i_iss_addr  in  AW  destination of issued op.

Function
REQ-017 No hardwired zero register; all DEPTH registers are read/write.
REQ-018 Effective write on port w = i_wr_en[w] & ~i_stall; takes effect at the next posedge.
REQ-019 Two ports writing the same address in one cycle: port 1 data is stored; port 0 data is dropped.
REQ-020 Read latency is one cycle: o_rd_data[r] at cycle N+1 reflects i_rd_addr[r] sampled at edge N.
REQ-021 Same-cycle write/read to one address: the read register captures the new write data (write-through bypass, port 1 priority).
REQ-022 While i_stall=1, o_rd_data and o_rd_busy hold their values and no storage or scoreboard bit changes.
REQ-023 Scoreboard holds DEPTH busy bits; i_iss_en & ~i_stall sets bit i_iss_addr.
REQ-024 Any effective write clears the busy bit of its address.
REQ-025 Set and clear of the same bit in one cycle: set wins, because the new issue is younger.
REQ-026 o_rd_busy[r] is computed from the post-update scoreboard, using the same bypass rule as data.
REQ-027 Out-of-range addresses cannot occur, since DEPTH is a power of two.

Reset
REQ-028 Asserting i_rst_n=0 immediately clears all busy bits, o_rd_data to 0 and o_rd_busy to 0.
REQ-029 Register storage is not reset; contents are undefined until written.
REQ-030 Reset mid-operation discards in-flight issues; completions arriving after reset release still write data but find busy already 0.

Configuration
REQ-031 Macro FP_RF_NAN_BOX_EN defined with DATA_WIDTH=64: writes with i_wr_single=1 store bits [63:32] as all ones.
REQ-032 Macro undefined, or DATA_WIDTH=32: data is stored unmodified and i_wr_single is ignored.

Structure
REQ-033 riscv_pkg holds FpWidth, the fp_rf_rd_t/fp_rf_wr_t port typedefs and the NaN-box constant.
REQ-034 Storage array and write-priority logic live in sub-module fp_rf_bank; the top level holds the scoreboard, bypass and read registers.

Verification
REQ-035 Write f5=0x3FF0_0000_0000_0000 on port 0, then read f5 on rd0 -> next cycle o_rd_data[0]=0x3FF0000000000000, busy 0.
REQ-036 Port 0 writes f7=0x11 and port 1 writes f7=0x22 in the same cycle; all three reads of f7 -> 0x22 on every port.
REQ-037 Issue f3, then complete f3 four cycles later with issue f3 in the same cycle -> o_rd_busy for f3 stays 1; a later write clears it to 0.
REQ-038 Write f9=0xAA while reading f9 in the same cycle -> o_rd_data=0xAA one cycle later (bypass).
REQ-039 Hold i_stall=1 for 3 cycles with write/issue active -> outputs frozen, f-reg unchanged after stall drops.
REQ-040 With FP_RF_NAN_BOX_EN, a single-precision write of 0x4049_0FDB -> read returns 0xFFFFFFFF40490FDB; without the macro, 0x0000000040490FDB.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared FP register file definitions: default FP width, default port
// record layouts, and the NaN-box upper word for single-precision values.
package riscv_pkg;

  localparam int FpWidth = 64;

  // Address width of the default 32-entry FP register file
  localparam int FpRfAw = 5;

  // Upper word that marks a boxed single-precision value in a 64-bit register
  localparam logic [31:0] NanBoxHi = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [FpRfAw-1:0] addr;
  } fp_rf_rd_t;

  typedef struct packed {
    logic              en;
    logic [FpRfAw-1:0] addr;
    logic [FpWidth-1:0] data;
    logic              single;
  } fp_rf_wr_t;

endpackage

// File: rtl/fp_rf_bank.sv
// FP register storage array with multi-port write priority (higher port
// index wins on an address collision) and optional NaN-boxing of
// single-precision writes, enabled by macro FP_RF_NAN_BOX_EN.
// Storage is deliberately not reset.
module fp_rf_bank
  import riscv_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = FpWidth,
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic [NUM_WR-1:0]                    we,
  input  logic [NUM_WR-1:0][AW-1:0]            waddr,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wdata,
  input  logic [NUM_WR-1:0]                    wsingle,
  input  logic [NUM_RD-1:0][AW-1:0]            raddr,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rdata,
  output logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wdata_fmt
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef FP_RF_NAN_BOX_EN
  // For 32-bit registers the truncation leaves an all-zero mask, so the
  // boxing degenerates to a plain store.
  localparam logic [DATA_WIDTH-1:0] BoxMask = DATA_WIDTH'({NanBoxHi, 32'h0});

  // Force the upper word to all ones for single-precision results
  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wdata_fmt[w] = wsingle[w] ? (wdata[w] | BoxMask) : wdata[w];
    end
  end
`else
  logic unused_single;
  assign unused_single = ^wsingle;

  // Data is stored exactly as presented
  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wdata_fmt[w] = wdata[w];
    end
  end
`endif

  // Apply writes in port order so a later port overrides an earlier one
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WR; w++) begin
      if (we[w]) begin
        mem[waddr[w]] <= wdata_fmt[w];
      end
    end
  end

  // Asynchronous array read; the top level registers and bypasses it
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rdata[r] = mem[raddr[r]];
    end
  end

endmodule

// File: rtl/fp_regfile_mp.sv
// Multi-port FP register file with busy scoreboard, write-through bypass
// and registered read data / busy outputs. The optional NaN-boxing of
// single-precision writes is controlled by macro FP_RF_NAN_BOX_EN.
module fp_regfile_mp
  import riscv_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = FpWidth,
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_stall,
  input  logic [NUM_RD-1:0][AW-1:0]         i_rd_addr,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0] o_rd_data,
  output logic [NUM_RD-1:0]                 o_rd_busy,
  input  logic [NUM_WR-1:0]                 i_wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]         i_wr_addr,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0] i_wr_data,
  input  logic [NUM_WR-1:0]                 i_wr_single,
  input  logic                              i_iss_en,
  input  logic [AW-1:0]                     i_iss_addr
);

  logic [NUM_WR-1:0]                 wr_eff;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] bank_rdata;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wdata_fmt;
  logic [DEPTH-1:0]                  busy;
  logic [DEPTH-1:0]                  busy_next;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_next;
  logic [NUM_RD-1:0]                 rd_busy_next;

  assign wr_eff = i_wr_en & {NUM_WR{~i_stall}};

  fp_rf_bank #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_RD     (NUM_RD),
    .NUM_WR     (NUM_WR),
    .AW         (AW)
  ) u_bank (
    .clk       (i_clk),
    .we        (wr_eff),
    .waddr     (i_wr_addr),
    .wdata     (i_wr_data),
    .wsingle   (i_wr_single),
    .raddr     (i_rd_addr),
    .rdata     (bank_rdata),
    .wdata_fmt (wdata_fmt)
  );

  // Scoreboard update: completions clear, a new issue sets and wins
  always_comb begin
    busy_next = busy;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_eff[w]) begin
        busy_next[i_wr_addr[w]] = 1'b0;
      end
    end
    if (i_iss_en && !i_stall) begin
      busy_next[i_iss_addr] = 1'b1;
    end
  end

  // Read path with write-through bypass, highest write port taking priority
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_next[r] = bank_rdata[r];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_eff[w] && (i_wr_addr[w] == i_rd_addr[r])) begin
          rd_next[r] = wdata_fmt[w];
        end
      end
      rd_busy_next[r] = busy_next[i_rd_addr[r]];
    end
  end

  // Register scoreboard and read outputs; a stall freezes all of them
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy      <= '0;
      o_rd_data <= '0;
      o_rd_busy <= '0;
    end else if (!i_stall) begin
      busy      <= busy_next;
      o_rd_data <= rd_next;
      o_rd_busy <= rd_busy_next;
    end
  end

endmodule

// File: tb/tb_fp_regfile_mp.sv
// Directed testbench for fp_regfile_mp (default parameters). Expected
// NaN-box result follows macro FP_RF_NAN_BOX_EN.
module tb_fp_regfile_mp;

  logic                i_clk;
  logic                i_rst_n;
  logic                i_stall;
  logic [2:0][4:0]     i_rd_addr;
  logic [2:0][63:0]    o_rd_data;
  logic [2:0]          o_rd_busy;
  logic [1:0]          i_wr_en;
  logic [1:0][4:0]     i_wr_addr;
  logic [1:0][63:0]    i_wr_data;
  logic [1:0]          i_wr_single;
  logic                i_iss_en;
  logic [4:0]          i_iss_addr;

  int checks = 0;
  int errors = 0;
  logic [63:0] box_exp;

  fp_regfile_mp dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_stall     (i_stall),
    .i_rd_addr   (i_rd_addr),
    .o_rd_data   (o_rd_data),
    .o_rd_busy   (o_rd_busy),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .i_wr_single (i_wr_single),
    .i_iss_en    (i_iss_en),
    .i_iss_addr  (i_iss_addr)
  );

  // Free-running clock, 10 time-unit period
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Drive all write/issue controls for the coming cycle
  task automatic applyStimulus(input logic [1:0] wen, input logic [4:0] wa0,
                               input logic [63:0] wd0, input logic [4:0] wa1,
                               input logic [63:0] wd1, input logic [1:0] sgl,
                               input logic iss, input logic [4:0] ia);
    i_wr_en      = wen;
    i_wr_addr[0] = wa0;
    i_wr_data[0] = wd0;
    i_wr_addr[1] = wa1;
    i_wr_data[1] = wd1;
    i_wr_single  = sgl;
    i_iss_en     = iss;
    i_iss_addr   = ia;
  endtask

  task automatic setRead(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    i_rd_addr[0] = a0;
    i_rd_addr[1] = a1;
    i_rd_addr[2] = a2;
  endtask

  // Advance one clock and land 1 time unit after the rising edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One comparison of an observed value against a bench-computed value
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef FP_RF_NAN_BOX_EN
    box_exp = 64'hFFFF_FFFF_4049_0FDB;
`else
    box_exp = 64'h0000_0000_4049_0FDB;
`endif
    i_rst_n = 1'b0;
    i_stall = 1'b0;
    setRead(5'd0, 5'd0, 5'd0);
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 1'b0, 5'd0);
    #2;
    checkOutput("reset_data0", o_rd_data[0], 64'h0);
    checkOutput("reset_data2", o_rd_data[2], 64'h0);
    checkOutput("reset_busy", {61'h0, o_rd_busy}, 64'h0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Port 0 write of f5, then read it back
    applyStimulus(2'b01, 5'd5, 64'h3FF0_0000_0000_0000, 5'd0, 64'h0, 2'b00, 1'b0, 5'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 1'b0, 5'd0);
    setRead(5'd5, 5'd0, 5'd0);
    tick();
    checkOutput("wr_f5_data", o_rd_data[0], 64'h3FF0_0000_0000_0000);
    checkOutput("wr_f5_busy", {63'h0, o_rd_busy[0]}, 64'h0);

    // Both ports write f7; port 1 must win on bypass and in storage
    setRead(5'd7, 5'd7, 5'd7);
    applyStimulus(2'b11, 5'd7, 64'h11, 5'd7, 64'h22, 2'b00, 1'b0, 5'd0);
    tick();
    checkOutput("coll_byp_rd0", o_rd_data[0], 64'h22);
    checkOutput("coll_byp_rd1", o_rd_data[1], 64'h22);
    checkOutput("coll_byp_rd2", o_rd_data[2], 64'h22);
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 1'b0, 5'd0);
    tick();
    checkOutput("coll_mem_rd0", o_rd_data[0], 64'h22);
    checkOutput("coll_mem_rd1", o_rd_data[1], 64'h22);
    checkOutput("coll_mem_rd2", o_rd_data[2], 64'h22);

    // Issue f3, hold, then complete and re-issue together: set wins
    setRead(5'd0, 5'd3, 5'd0);
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 1'b1, 5'd3);
    tick();
    checkOutput("iss_f3_busy", {63'h0, o_rd_busy[1]}, 64'h1);
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 1'b0, 5'd0);
    tick();
    tick();
    tick();
    checkOutput("iss_f3_hold", {63'h0, o_rd_busy[1]}, 64'h1);
    applyStimulus(2'b01, 5'd3, 64'h33, 5'd0, 64'h0, 2'b00, 1'b1, 5'd3);
    tick();
    checkOutput("setclr_busy", {63'h0, o_rd_busy[1]}, 64'h1);
    checkOutput("setclr_data", o_rd_data[1], 64'h33);
    applyStimulus(2'b10, 5'd0, 64'h0, 5'd3, 64'h44, 2'b00, 1'b0, 5'd0);
    tick();
    checkOutput("clr_f3_busy", {63'h0, o_rd_busy[1]}, 64'h0);
    checkOutput("clr_f3_data", o_rd_data[1], 64'h44);

    // Same-cycle write and read of f9
    setRead(5'd0, 5'd0, 5'd9);
    applyStimulus(2'b10, 5'd0, 64'h0, 5'd9, 64'hAA, 2'b00, 1'b0, 5'd0);
    tick();
    checkOutput("byp_f9_data", o_rd_data[2], 64'hAA);
    checkOutput("byp_f9_busy", {63'h0, o_rd_busy[2]}, 64'h0);

    // Establish known outputs, then stall with writes/issue active
    setRead(5'd9, 5'd3, 5'd7);
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 1'b0, 5'd0);
    tick();
    checkOutput("pre_stall_rd0", o_rd_data[0], 64'hAA);
    i_stall = 1'b1;
    setRead(5'd5, 5'd5, 5'd5);
    applyStimulus(2'b11, 5'd9, 64'hBB, 5'd7, 64'hCC, 2'b00, 1'b1, 5'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_rd0", o_rd_data[0], 64'hAA);
      checkOutput("stall_busy1", {63'h0, o_rd_busy[1]}, 64'h0);
    end
    i_stall = 1'b0;
    setRead(5'd9, 5'd3, 5'd7);
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 1'b0, 5'd0);
    tick();
    checkOutput("post_stall_f9", o_rd_data[0], 64'hAA);
    checkOutput("post_stall_f3", o_rd_data[1], 64'h44);
    checkOutput("post_stall_f7", o_rd_data[2], 64'h22);
    checkOutput("post_stall_busy", {61'h0, o_rd_busy}, 64'h0);

    // Single-precision write of f10, via bypass then from storage
    setRead(5'd10, 5'd0, 5'd0);
    applyStimulus(2'b01, 5'd10, 64'h0000_0000_4049_0FDB, 5'd0, 64'h0, 2'b01, 1'b0, 5'd0);
    tick();
    checkOutput("box_byp", o_rd_data[0], box_exp);
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 1'b0, 5'd0);
    tick();
    checkOutput("box_mem", o_rd_data[0], box_exp);

    // Reset during an in-flight issue of f12, then late completion
    setRead(5'd12, 5'd0, 5'd0);
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 1'b1, 5'd12);
    tick();
    checkOutput("iss_f12_busy", {63'h0, o_rd_busy[0]}, 64'h1);
    applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 2'b00, 1'b0, 5'd0);
    i_rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_data", o_rd_data[0], 64'h0);
    checkOutput("rst_mid_busy", {63'h0, o_rd_busy[0]}, 64'h0);
    tick();
    i_rst_n = 1'b1;
    tick();
    checkOutput("rst_f12_busy", {63'h0, o_rd_busy[0]}, 64'h0);
    applyStimulus(2'b01, 5'd12, 64'h55, 5'd0, 64'h0, 2'b00, 1'b0, 5'd0);
    tick();
    checkOutput("late_cmpl_data", o_rd_data[0], 64'h55);
    checkOutput("late_cmpl_busy", {63'h0, o_rd_busy[0]}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
